// File: rtl/serial_rx_pkg.sv
// Shared constants, state encoding and frame payload for the odd-parity serial byte receiver.
package serial_rx_pkg;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned DATA_BITS  = 8;
   localparam logic        ODD_PARITY = 1'b1;

   localparam int unsigned ST_W = 3;
   typedef logic [ST_W-1:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;
   localparam state_t ST_BREAK  = 3'd5;

   // Byte plus its error flags as handed to the consumer.
   typedef struct packed {
      logic [DATA_BITS-1:0] data;
      logic                 perr;
      logic                 ferr;
   } rx_frame_t;

   // High when the nine received bits do not XOR to the odd-parity value.
   function automatic logic parity_err(input logic [DATA_BITS-1:0] data, input logic par);
      return (^{data, par}) != ODD_PARITY;
   endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module serial_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d};
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/serial_rx_frame_ctrl.sv
// Oversampling frame controller: times and samples each bit at mid-bit, checks
// odd parity and stop bit, and delivers the byte over valid/ready with overrun detection.
module serial_rx_frame_ctrl
   import serial_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_data,
   output logic [DATA_BITS-1:0] o_byte,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_perr,
   output logic                 o_ferr,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int unsigned    IDX_W    = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic rx_s;

   serial_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (i_data),
      .q   (rx_s)
   );

   state_t               state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [IDX_W-1:0]     idx_q,     idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 par_q,     par_d;
   rx_frame_t            frame_q,   frame_d;
   logic                 valid_q,   valid_d;
   logic                 overrun_q, overrun_d;
   logic                 busy_q,    busy_d;
   logic                 bit_end;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         frame_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state, bit timing and delivery logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      frame_d   = frame_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      bit_end   = (cnt_q == CNT_LAST);

      if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end

         // Confirm the start bit at its midpoint; a high line here is a glitch.
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               cnt_d   = '0;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = ST_PARITY;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_PARITY: begin
            if (bit_end) begin
               par_d   = rx_s;
               cnt_d   = '0;
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
         ST_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (!valid_q || i_ready) begin
                  frame_d.data = shift_q;
                  frame_d.perr = parity_err(shift_q, par_q);
                  frame_d.ferr = !rx_s;
                  valid_d      = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
               state_d = rx_s ? ST_IDLE : ST_BREAK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign o_byte    = frame_q.data;
   assign o_perr    = frame_q.perr;
   assign o_ferr    = frame_q.ferr;
   assign o_valid   = valid_q;
   assign o_overrun = overrun_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_serial_rx_frame_ctrl.sv
// Directed bench for serial_rx_frame_ctrl with hand-computed frames and expected results.
module tb_serial_rx_frame_ctrl;

   localparam int CPB = 16;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       i_data  = 1'b1;
   logic       i_ready = 1'b0;
   logic [7:0] o_byte;
   logic       o_valid;
   logic       o_perr;
   logic       o_ferr;
   logic       o_overrun;
   logic       o_busy;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int valid_cnt = 0;
   int valid_hi  = 0;
   int ovr_cnt   = 0;
   int rise_cyc  = 0;

   logic       prev_valid = 1'b0;
   logic [7:0] cap_byte   = 8'h00;
   logic       cap_perr   = 1'b0;
   logic       cap_ferr   = 1'b0;

   always #5 clk = ~clk;

   serial_rx_frame_ctrl #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_data    (i_data),
      .o_byte    (o_byte),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_perr    (o_perr),
      .o_ferr    (o_ferr),
      .o_overrun (o_overrun),
      .o_busy    (o_busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Capture each new delivery on the falling edge.
   always @(negedge clk) begin
      if (o_valid && !prev_valid) begin
         valid_cnt = valid_cnt + 1;
         rise_cyc  = cyc;
         cap_byte  = o_byte;
         cap_perr  = o_perr;
         cap_ferr  = o_ferr;
      end
      if (o_valid)   valid_hi = valid_hi + 1;
      if (o_overrun) ovr_cnt  = ovr_cnt + 1;
      prev_valid = o_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                             output int start_cyc);
      logic [10:0] bits;
      bits      = {stp, par, b, 1'b0};
      start_cyc = cyc;
      for (int i = 0; i < 11; i++) begin
         i_data = bits[i];
         tick(CPB);
      end
   endtask

   task automatic test_reset();
      tick(3);
      checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
      checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
      checks++; if (o_byte !== 8'h00)   begin errors++; $display("FAIL reset_byte got %h want 00", o_byte); end
      checks++; if (o_perr !== 1'b0)    begin errors++; $display("FAIL reset_perr got %b want 0", o_perr); end
      checks++; if (o_ferr !== 1'b0)    begin errors++; $display("FAIL reset_ferr got %b want 0", o_ferr); end
      checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
      rst = 1'b1;
      tick(20);
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL idle_busy got %b want 0", o_busy); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", o_valid); end
   endtask

   task automatic test_clean();
      int t, v0, h0, lat;
      i_ready = 1'b1;
      v0 = valid_cnt;
      h0 = valid_hi;
      send_frame(8'hA5, 1'b1, 1'b1, t);
      lat = rise_cyc - t;
      checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL clean_count got %0d want %0d", valid_cnt - v0, 1); end
      checks++; if (cap_byte !== 8'hA5)   begin errors++; $display("FAIL clean_byte got %h want a5", cap_byte); end
      checks++; if (cap_perr !== 1'b0)    begin errors++; $display("FAIL clean_perr got %b want 0", cap_perr); end
      checks++; if (cap_ferr !== 1'b0)    begin errors++; $display("FAIL clean_ferr got %b want 0", cap_ferr); end
      checks++; if (lat < 170 || lat > 172) begin errors++; $display("FAIL clean_latency got %0d want 171+-1", lat); end
      checks++; if (valid_hi - h0 !== 1)  begin errors++; $display("FAIL clean_valid_width got %0d want 1", valid_hi - h0); end
      tick(CPB);
   endtask

   task automatic test_parity();
      int t;
      send_frame(8'h3C, 1'b0, 1'b1, t);
      checks++; if (cap_byte !== 8'h3C) begin errors++; $display("FAIL par_bad_byte got %h want 3c", cap_byte); end
      checks++; if (cap_perr !== 1'b1)  begin errors++; $display("FAIL par_bad_perr got %b want 1", cap_perr); end
      send_frame(8'h01, 1'b0, 1'b1, t);
      checks++; if (cap_byte !== 8'h01) begin errors++; $display("FAIL par_ok_byte got %h want 01", cap_byte); end
      checks++; if (cap_perr !== 1'b0)  begin errors++; $display("FAIL par_ok_perr got %b want 0", cap_perr); end
      tick(CPB);
   endtask

   task automatic test_glitch();
      int v0, n;
      v0 = valid_cnt;
      i_data = 1'b0;
      tick(5);
      i_data = 1'b1;
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b want 1", o_busy); end
      n = 0;
      while (o_busy && n < 10) begin
         tick(1);
         n++;
      end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got %b want 0 within 10", o_busy); end
      tick(40);
      checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL glitch_no_output got %0d want 0", valid_cnt - v0); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", o_valid); end
   endtask

   task automatic test_break();
      int t, v0;
      v0 = valid_cnt;
      send_frame(8'h55, 1'b1, 1'b0, t);
      tick(40);
      checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL break_count got %0d want 1", valid_cnt - v0); end
      checks++; if (cap_byte !== 8'h55)   begin errors++; $display("FAIL break_byte got %h want 55", cap_byte); end
      checks++; if (cap_ferr !== 1'b1)    begin errors++; $display("FAIL break_ferr got %b want 1", cap_ferr); end
      checks++; if (cap_perr !== 1'b0)    begin errors++; $display("FAIL break_perr got %b want 0", cap_perr); end
      checks++; if (o_busy !== 1'b1)      begin errors++; $display("FAIL break_hold_busy got %b want 1", o_busy); end
      i_data = 1'b1;
      tick(5);
      checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL break_exit_busy got %b want 0", o_busy); end
      tick(CPB);
      send_frame(8'h12, 1'b1, 1'b1, t);
      checks++; if (valid_cnt !== v0 + 2) begin errors++; $display("FAIL after_break_count got %0d want 2", valid_cnt - v0); end
      checks++; if (cap_byte !== 8'h12)   begin errors++; $display("FAIL after_break_byte got %h want 12", cap_byte); end
      checks++; if (cap_ferr !== 1'b0 || cap_perr !== 1'b0) begin
         errors++; $display("FAIL after_break_flags got perr=%b ferr=%b want 0 0", cap_perr, cap_ferr);
      end
      tick(CPB);
   endtask

   task automatic test_back_to_back();
      int t, v0, ov0;
      i_ready = 1'b0;
      v0  = valid_cnt;
      ov0 = ovr_cnt;
      send_frame(8'h11, 1'b1, 1'b1, t);
      send_frame(8'h22, 1'b1, 1'b1, t);
      checks++; if (o_valid !== 1'b1)      begin errors++; $display("FAIL b2b_valid_held got %b want 1", o_valid); end
      checks++; if (o_byte !== 8'h11)      begin errors++; $display("FAIL b2b_byte_held got %h want 11", o_byte); end
      checks++; if (o_perr !== 1'b0 || o_ferr !== 1'b0) begin
         errors++; $display("FAIL b2b_flags got perr=%b ferr=%b want 0 0", o_perr, o_ferr);
      end
      checks++; if (ovr_cnt !== ov0 + 1)   begin errors++; $display("FAIL b2b_overrun_pulse got %0d want 1", ovr_cnt - ov0); end
      checks++; if (valid_cnt !== v0 + 1)  begin errors++; $display("FAIL b2b_deliveries got %0d want 1", valid_cnt - v0); end
      i_ready = 1'b1;
      tick(1);
      checks++; if (o_valid !== 1'b0)      begin errors++; $display("FAIL b2b_accept got %b want 0", o_valid); end
      tick(CPB);
   endtask

   task automatic test_reset_mid();
      int t, v0;
      v0 = valid_cnt;
      i_data = 1'b0;
      tick(CPB * 5 + CPB / 2);
      rst = 1'b0;
      tick(1);
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy got %b want 0", o_busy); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", o_valid); end
      i_data = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(40);
      checks++; if (o_busy !== 1'b0 || valid_cnt !== v0) begin
         errors++; $display("FAIL rst_mid_abandon got busy=%b out=%0d want 0 0", o_busy, valid_cnt - v0);
      end
      send_frame(8'h7E, 1'b1, 1'b1, t);
      checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL rst_mid_count got %0d want 1", valid_cnt - v0); end
      checks++; if (cap_byte !== 8'h7E)   begin errors++; $display("FAIL rst_mid_byte got %h want 7e", cap_byte); end
      checks++; if (cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin
         errors++; $display("FAIL rst_mid_flags got perr=%b ferr=%b want 0 0", cap_perr, cap_ferr);
      end
      tick(CPB);
   endtask

   initial begin
      #1 rst = 1'b0;
      test_reset();
      test_clean();
      test_parity();
      test_glitch();
      test_break();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
